// File: rtl/cyclic_fixpoint_seq.sv
// Iterative evaluator for the cyclic network f = x | (x & f). The loop is broken by f_q and
// stepped once per clock until f settles or the budget runs out. CYCLIC_FIXPOINT_SEQ_ABORT_EN adds an abort input.
module cyclic_fixpoint_seq #(
  parameter int             W        = 1,
  parameter int             MAX_ITER = 8,
  parameter logic [W-1:0]   F_INIT   = '0,
  localparam int            IW       = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CYCLIC_FIXPOINT_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [W-1:0]  in_x,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_f,
  output logic          res_converged,
  output logic [IW-1:0] res_iters
);

  // state | meaning
  // IDLE  | waiting for a request, start_ready high
  // EVAL  | one network step per clock from the registered x_q/f_q
  // HOLD  | result presented until the consumer takes it
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t        state_q;
  logic [W-1:0]  x_q, f_q, res_f_q;
  logic [IW-1:0] iter_q, res_iters_q, iter_d;
  logic          res_conv_q;
  logic [W-1:0]  f_d;

  assign f_d    = x_q | (x_q & f_q);
  assign iter_d = iter_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      f_q         <= '0;
      iter_q      <= '0;
      res_f_q     <= '0;
      res_conv_q  <= 1'b0;
      res_iters_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            x_q     <= in_x;
            f_q     <= F_INIT;
            iter_q  <= '0;
            state_q <= EVAL;
          end
        end
        EVAL: begin
`ifdef CYCLIC_FIXPOINT_SEQ_ABORT_EN
          if (abort) state_q <= IDLE; else
`endif
          if (f_d == f_q) begin
            res_f_q     <= f_q;
            res_conv_q  <= 1'b1;
            res_iters_q <= iter_q;
            state_q     <= HOLD;
          end else if (iter_d == IW'(MAX_ITER)) begin
            // budget spent: report the last step unconverged
            res_f_q     <= f_d;
            res_conv_q  <= 1'b0;
            res_iters_q <= IW'(MAX_ITER);
            state_q     <= HOLD;
          end else begin
            f_q    <= f_d;
            iter_q <= iter_d;
          end
        end
        HOLD: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready   = (state_q == IDLE);
  assign res_valid     = (state_q == HOLD);
  assign res_f         = res_f_q;
  assign res_converged = res_conv_q;
  assign res_iters     = res_iters_q;

endmodule

// File: tb/tb_cyclic_fixpoint_seq.sv
// Directed bench for cyclic_fixpoint_seq: three instances cover default, MAX_ITER=1 and W=4.
module tb_cyclic_fixpoint_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance 0: W=1, MAX_ITER=8
  logic sv0 = 0, ix0 = 0, rr0 = 1, ab0 = 0;
  logic sr0, rv0, rf0, rc0;
  logic [3:0] ri0;
  // instance 1: W=1, MAX_ITER=1
  logic sv1 = 0, ix1 = 0, rr1 = 1, ab1 = 0;
  logic sr1, rv1, rf1, rc1;
  logic [0:0] ri1;
  // instance 4: W=4, MAX_ITER=8
  logic sv4 = 0, rr4 = 1, ab4 = 0;
  logic [3:0] ix4 = '0;
  logic sr4, rv4, rc4;
  logic [3:0] rf4, ri4;

  cyclic_fixpoint_seq #(.W(1), .MAX_ITER(8), .F_INIT(1'b0)) u0 (
    .clk(clk), .rst(rst),
`ifdef CYCLIC_FIXPOINT_SEQ_ABORT_EN
    .abort(ab0),
`endif
    .start_valid(sv0), .start_ready(sr0), .in_x(ix0), .res_valid(rv0),
    .res_ready(rr0), .res_f(rf0), .res_converged(rc0), .res_iters(ri0));

  cyclic_fixpoint_seq #(.W(1), .MAX_ITER(1), .F_INIT(1'b0)) u1 (
    .clk(clk), .rst(rst),
`ifdef CYCLIC_FIXPOINT_SEQ_ABORT_EN
    .abort(ab1),
`endif
    .start_valid(sv1), .start_ready(sr1), .in_x(ix1), .res_valid(rv1),
    .res_ready(rr1), .res_f(rf1), .res_converged(rc1), .res_iters(ri1));

  cyclic_fixpoint_seq #(.W(4), .MAX_ITER(8), .F_INIT(4'b0000)) u4 (
    .clk(clk), .rst(rst),
`ifdef CYCLIC_FIXPOINT_SEQ_ABORT_EN
    .abort(ab4),
`endif
    .start_valid(sv4), .start_ready(sr4), .in_x(ix4), .res_valid(rv4),
    .res_ready(rr4), .res_f(rf4), .res_converged(rc4), .res_iters(ri4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // issue one request on u0 and count edges from accept until res_valid
  task automatic u0_request(input logic x, output int lat);
    sv0 = 1'b1; ix0 = x;
    tick;
    sv0 = 1'b0;
    lat = 0;
    while (rv0 !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    total++; if ({sr0, rv0, rf0, rc0, ri0} !== 8'b1000_0000) begin bad++;
      $display("FAIL reset_u0: got %b want 10000000", {sr0, rv0, rf0, rc0, ri0}); end
    total++; if ({sr1, rv1, rc1, ri1} !== 4'b1000) begin bad++;
      $display("FAIL reset_u1: got %b want 1000", {sr1, rv1, rc1, ri1}); end
    total++; if ({sr4, rv4, rf4, rc4, ri4} !== 11'b10_0000_0_0000) begin bad++;
      $display("FAIL reset_u4: got %b want 10000000000", {sr4, rv4, rf4, rc4, ri4}); end
  endtask

  task automatic test_zero_input;
    int lat;
    rr0 = 1'b1;
    u0_request(1'b0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
    total++; if ({rf0, rc0, ri0} !== 6'b0_1_0000) begin bad++;
      $display("FAIL zero_result: got f=%b c=%b i=%0d want f=0 c=1 i=0", rf0, rc0, ri0); end
    tick;
    total++; if ({sr0, rv0} !== 2'b10) begin bad++;
      $display("FAIL zero_release: got sr=%b rv=%b want sr=1 rv=0", sr0, rv0); end
  endtask

  task automatic test_one_input;
    int lat;
    u0_request(1'b1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL one_latency: got %0d want 2", lat); end
    total++; if ({rf0, rc0, ri0} !== 6'b1_1_0001) begin bad++;
      $display("FAIL one_result: got f=%b c=%b i=%0d want f=1 c=1 i=1", rf0, rc0, ri0); end
    tick;
  endtask

  task automatic test_budget;
    int lat;
    sv1 = 1'b1; ix1 = 1'b1; rr1 = 1'b1;
    tick;
    sv1 = 1'b0;
    lat = 0;
    while (rv1 !== 1'b1 && lat < 20) begin tick; lat++; end
    total++; if (lat !== 1) begin bad++; $display("FAIL budget_latency: got %0d want 1", lat); end
    total++; if ({rf1, rc1, ri1} !== 3'b1_0_1) begin bad++;
      $display("FAIL budget_result: got f=%b c=%b i=%0d want f=1 c=0 i=1", rf1, rc1, ri1); end
    tick;
  endtask

  task automatic test_hold_backpressure;
    int lat;
    int errs;
    rr4 = 1'b0;
    sv4 = 1'b1; ix4 = 4'b1010;
    tick;
    sv4 = 1'b0;
    lat = 0;
    while (rv4 !== 1'b1 && lat < 20) begin tick; lat++; end
    total++; if (lat !== 2) begin bad++; $display("FAIL hold_latency: got %0d want 2", lat); end
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if ({rv4, sr4, rf4, rc4, ri4} !== 11'b1_0_1010_1_0001) errs++;
      sv4 = (i % 2 == 0); ix4 = 4'b0101;
      tick;
    end
    sv4 = 1'b0;
    total++; if (errs !== 0) begin bad++;
      $display("FAIL hold_stable: got %0d bad cycles want 0", errs); end
    total++; if ({rv4, rf4, ri4} !== 9'b1_1010_0001) begin bad++;
      $display("FAIL hold_after_pulses: got rv=%b f=%b i=%0d want rv=1 f=1010 i=1", rv4, rf4, ri4); end
    rr4 = 1'b1;
    tick;
    total++; if ({sr4, rv4, rf4} !== 6'b10_1010) begin bad++;
      $display("FAIL hold_release: got sr=%b rv=%b f=%b want sr=1 rv=0 f=1010", sr4, rv4, rf4); end
  endtask

  task automatic test_reset_mid_eval;
    int lat;
    int seen;
    rr0 = 1'b1;
    sv0 = 1'b1; ix0 = 1'b1;
    tick;
    sv0 = 1'b0;
    total++; if (sr0 !== 1'b0) begin bad++; $display("FAIL midrst_in_eval: got sr=%b want 0", sr0); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++; if ({sr0, rv0, rf0, rc0, ri0} !== 8'b1000_0000) begin bad++;
      $display("FAIL midrst_outputs: got %b want 10000000", {sr0, rv0, rf0, rc0, ri0}); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick; if (rv0 !== 1'b0) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
    u0_request(1'b1, lat);
    total++; if (lat !== 2 || {rf0, rc0, ri0} !== 6'b1_1_0001) begin bad++;
      $display("FAIL midrst_rerun: got lat=%0d f=%b c=%b i=%0d want lat=2 f=1 c=1 i=1", lat, rf0, rc0, ri0); end
    tick;
    rst = 1'b1; sv0 = 1'b1; ix0 = 1'b1;
    tick;
    rst = 1'b0; sv0 = 1'b0;
    total++; if (sr0 !== 1'b1) begin bad++; $display("FAIL rst_beats_start: got sr=%b want 1", sr0); end
    tick;
    total++; if ({sr0, rv0} !== 2'b10) begin bad++;
      $display("FAIL rst_beats_start_idle: got sr=%b rv=%b want sr=1 rv=0", sr0, rv0); end
  endtask

`ifdef CYCLIC_FIXPOINT_SEQ_ABORT_EN
  task automatic test_abort;
    int lat;
    int seen;
    rr0 = 1'b1;
    u0_request(1'b0, lat);
    tick;
    sv0 = 1'b1; ix0 = 1'b1;
    tick;
    sv0 = 1'b0; ab0 = 1'b1;
    tick;
    ab0 = 1'b0;
    total++; if ({sr0, rv0, rf0, rc0, ri0} !== 8'b10_0_1_0000) begin bad++;
      $display("FAIL abort_state: got %b want 10010000", {sr0, rv0, rf0, rc0, ri0}); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick; if (rv0 !== 1'b0 || ri0 !== 4'd0) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_result: got %0d bad cycles want 0", seen); end
  endtask
`endif

  initial begin
    test_reset;
    test_zero_input;
    test_one_input;
    test_budget;
    test_hold_backpressure;
    test_reset_mid_eval;
`ifdef CYCLIC_FIXPOINT_SEQ_ABORT_EN
    test_abort;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
